// File: rtl/panel_scan_scheduler.sv
// Bitplane scan scheduler for an LED matrix panel: sequences row shifting, blank/latch
// timing, binary-weighted plane on-times and frame-boundary double-buffer swaps.
module panel_scan_scheduler #(
  parameter int unsigned ROW_BITS   = 3,
  parameter int unsigned PLANE_BITS = 2,
  parameter int unsigned BASE_ON    = 32,
  parameter int unsigned TIMER_BITS = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  enable,
  output logic                  shift_start,
  output logic [ROW_BITS-1:0]   shift_row,
  output logic [PLANE_BITS-1:0] shift_plane,
  input  logic                  shift_done,
  output logic                  lp_blank,
  output logic                  lp_latch,
  output logic [ROW_BITS-1:0]   lp_address,
  input  logic                  swap_req,
  output logic                  swap_ack,
  output logic                  buffer_sel,
  output logic                  frame_tick
);

  localparam int unsigned POS_W = ROW_BITS + PLANE_BITS;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT,
    WAIT_ON,
    BLANK,
    LATCH,
    UNBLANK,
    DRAIN
  } state_e;

  state_e                state_q, state_d;
  logic [TIMER_BITS-1:0] timer_q, timer_d;
  logic                  shift_start_q, shift_start_d;
  logic [ROW_BITS-1:0]   shift_row_q, shift_row_d;
  logic [PLANE_BITS-1:0] shift_plane_q, shift_plane_d;
  logic                  lp_blank_q, lp_blank_d;
  logic                  lp_latch_q, lp_latch_d;
  logic [ROW_BITS-1:0]   lp_address_q, lp_address_d;
  logic                  swap_ack_q, swap_ack_d;
  logic                  buffer_sel_q, buffer_sel_d;
  logic                  frame_tick_q, frame_tick_d;

  logic                  timer_expiring;
  logic                  last_pos;

  // Expiry tests the value the timer reaches this cycle, so lit spans are exactly BASE_ON<<p.
  assign timer_expiring = (timer_q <= TIMER_BITS'(1));
  assign last_pos       = (&shift_row_q) & (&shift_plane_q);

  // State and output registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      shift_start_q <= 1'b0;
      shift_row_q   <= '0;
      shift_plane_q <= '0;
      lp_blank_q    <= 1'b1;
      lp_latch_q    <= 1'b0;
      lp_address_q  <= '0;
      swap_ack_q    <= 1'b0;
      buffer_sel_q  <= 1'b0;
      frame_tick_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      shift_start_q <= shift_start_d;
      shift_row_q   <= shift_row_d;
      shift_plane_q <= shift_plane_d;
      lp_blank_q    <= lp_blank_d;
      lp_latch_q    <= lp_latch_d;
      lp_address_q  <= lp_address_d;
      swap_ack_q    <= swap_ack_d;
      buffer_sel_q  <= buffer_sel_d;
      frame_tick_q  <= frame_tick_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state_q;
    timer_d       = (timer_q != '0) ? timer_q - TIMER_BITS'(1) : timer_q;
    shift_start_d = 1'b0;
    shift_row_d   = shift_row_q;
    shift_plane_d = shift_plane_q;
    lp_blank_d    = lp_blank_q;
    lp_latch_d    = 1'b0;
    lp_address_d  = lp_address_q;
    swap_ack_d    = 1'b0;
    buffer_sel_d  = buffer_sel_q;
    frame_tick_d  = 1'b0;

    case (state_q)
      IDLE: begin
        lp_blank_d = 1'b1;
        if (enable) begin
          shift_start_d = 1'b1;
          state_d       = SHIFT;
        end
      end
      SHIFT: begin
        if (shift_done) begin
          state_d = WAIT_ON;
        end
      end
      WAIT_ON: begin
        if (timer_expiring) begin
          lp_blank_d = 1'b1;
          state_d    = BLANK;
        end
      end
      BLANK: begin
        lp_latch_d   = 1'b1;
        lp_address_d = shift_row_q;
        state_d      = LATCH;
      end
      LATCH: begin
        lp_blank_d = 1'b0;
        timer_d    = TIMER_BITS'(BASE_ON) << shift_plane_q;
        state_d    = UNBLANK;
      end
      UNBLANK: begin
        // Frame boundary: swap here so the following (0,0) shift reads the new buffer
        if (last_pos) begin
          frame_tick_d = 1'b1;
          if (swap_req) begin
            buffer_sel_d = ~buffer_sel_q;
            swap_ack_d   = 1'b1;
          end
        end
        if (enable) begin
          {shift_row_d, shift_plane_d} = {shift_row_q, shift_plane_q} + POS_W'(1);
          shift_start_d = 1'b1;
          state_d       = SHIFT;
        end else begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (timer_expiring) begin
          lp_blank_d    = 1'b1;
          shift_row_d   = '0;
          shift_plane_d = '0;
          state_d       = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign shift_start = shift_start_q;
  assign shift_row   = shift_row_q;
  assign shift_plane = shift_plane_q;
  assign lp_blank    = lp_blank_q;
  assign lp_latch    = lp_latch_q;
  assign lp_address  = lp_address_q;
  assign swap_ack    = swap_ack_q;
  assign buffer_sel  = buffer_sel_q;
  assign frame_tick  = frame_tick_q;

endmodule

// File: tb/tb_panel_scan_scheduler.sv
// Self-checking bench for panel_scan_scheduler: a shifter responder plus an event
// monitor feed queues that each test compares against a scan-order model.
module tb_panel_scan_scheduler;

  localparam int unsigned ROW_BITS   = 3;
  localparam int unsigned PLANE_BITS = 2;
  localparam int unsigned BASE_ON    = 32;
  localparam int unsigned TIMER_BITS = 16;
  localparam int NPLANES = 4;
  localparam int NROWS   = 8;
  localparam int NPOS    = NPLANES * NROWS;

  logic                  clock = 1'b0;
  logic                  reset_n = 1'b0;
  logic                  enable = 1'b0;
  logic                  shift_done = 1'b0;
  logic                  swap_req = 1'b0;
  logic                  shift_start;
  logic [ROW_BITS-1:0]   shift_row;
  logic [PLANE_BITS-1:0] shift_plane;
  logic                  lp_blank;
  logic                  lp_latch;
  logic [ROW_BITS-1:0]   lp_address;
  logic                  swap_ack;
  logic                  buffer_sel;
  logic                  frame_tick;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // shifter model controls
  int done_at = -1;
  int rand_delay = 0;
  int slow_idx = -1;
  int slow_delay = 0;
  int slow_done_cyc = -1;

  // monitor logs
  int start_q[$];
  int start_cyc_q[$];
  int lat_addr_q[$];
  int lat_cyc_q[$];
  int low_q[$];
  int rise_cyc_q[$];
  int win_len_q[$];
  int win_at_q[$];
  int tick_cyc_q[$];
  int tick_ack_q[$];
  int tick_buf_q[$];
  int ack_cnt = 0;
  int latch_while_lit = 0;
  bit prev_blank = 1'b1;
  int low_cnt = 0;
  int high_cnt = 0;
  int latch_at = 0;

  panel_scan_scheduler #(
    .ROW_BITS  (ROW_BITS),
    .PLANE_BITS(PLANE_BITS),
    .BASE_ON   (BASE_ON),
    .TIMER_BITS(TIMER_BITS)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .enable     (enable),
    .shift_start(shift_start),
    .shift_row  (shift_row),
    .shift_plane(shift_plane),
    .shift_done (shift_done),
    .lp_blank   (lp_blank),
    .lp_latch   (lp_latch),
    .lp_address (lp_address),
    .swap_req   (swap_req),
    .swap_ack   (swap_ack),
    .buffer_sel (buffer_sel),
    .frame_tick (frame_tick)
  );

  always #5 clock = ~clock;

  // reference scan order: plane-inner, row-outer
  function automatic int exp_row(input int n);
    return (n / NPLANES) % NROWS;
  endfunction
  function automatic int exp_plane(input int n);
    return n % NPLANES;
  endfunction
  function automatic int exp_pos(input int n);
    return exp_row(n) * NPLANES + exp_plane(n);
  endfunction
  function automatic int on_time(input int p);
    return int'(BASE_ON) << p;
  endfunction

  // cycle counter and shift_done responder
  initial forever begin
    @(posedge clock);
    cyc++;
    #1 shift_done = (cyc == done_at);
  end

  // event monitor, sampled on the falling edge
  initial forever begin
    int d;
    @(negedge clock);
    if (reset_n) begin
      if (shift_start) begin
        start_q.push_back(int'({shift_row, shift_plane}));
        start_cyc_q.push_back(cyc);
        if (start_q.size() - 1 == slow_idx) begin
          d = slow_delay;
          slow_done_cyc = cyc + d;
        end else if (rand_delay != 0) begin
          d = int'($urandom_range(1, 25));
        end else begin
          d = 5;
        end
        done_at = cyc + d;
      end
      if (lp_latch) begin
        lat_addr_q.push_back(int'(lp_address));
        lat_cyc_q.push_back(cyc);
      end
      if (lp_blank) begin
        if (!prev_blank) begin
          low_q.push_back(low_cnt);
          rise_cyc_q.push_back(cyc);
          high_cnt = 0;
          latch_at = 0;
        end
        high_cnt++;
        if (lp_latch) latch_at = high_cnt;
      end else begin
        if (prev_blank) begin
          if (latch_at != 0) begin
            win_len_q.push_back(high_cnt);
            win_at_q.push_back(latch_at);
          end
          low_cnt = 0;
        end
        low_cnt++;
        if (lp_latch) latch_while_lit++;
      end
      prev_blank = lp_blank;
      if (frame_tick) begin
        tick_cyc_q.push_back(cyc);
        tick_ack_q.push_back(int'(swap_ack));
        tick_buf_q.push_back(int'(buffer_sel));
      end
      if (swap_ack) ack_cnt++;
    end
  end

  task automatic clear_logs();
    start_q.delete(); start_cyc_q.delete(); lat_addr_q.delete(); lat_cyc_q.delete();
    low_q.delete(); rise_cyc_q.delete(); win_len_q.delete(); win_at_q.delete();
    tick_cyc_q.delete(); tick_ack_q.delete(); tick_buf_q.delete();
    ack_cnt = 0; latch_while_lit = 0; prev_blank = 1'b1;
    low_cnt = 0; high_cnt = 0; latch_at = 0;
    done_at = -1; slow_idx = -1; slow_done_cyc = -1;
  endtask

  task automatic do_reset();
    @(posedge clock);
    #1 reset_n = 1'b0; enable = 1'b0; swap_req = 1'b0;
    repeat (3) @(posedge clock);
    #1 clear_logs();
    reset_n = 1'b1;
  endtask

  task automatic wait_latches(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock); #1;
      if (lat_addr_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_ticks(input int n, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clock); #1;
      if (tick_cyc_q.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    logic [14:0] got;
    int c;
    @(posedge clock);
    #1 reset_n = 1'b0;
    #2;
    got = {shift_start, shift_row, shift_plane, lp_blank, lp_latch, lp_address,
           swap_ack, buffer_sel, frame_tick};
    checks++; if (got !== 15'b0_000_00_1_0_000_0_0_0) begin errors++;
      $display("FAIL reset_outputs: got %b expected %b", got, 15'b0_000_00_1_0_000_0_0_0); end
    do_reset();
    repeat (20) @(posedge clock);
    #1;
    checks++; if (start_q.size() != 0) begin errors++;
      $display("FAIL idle_no_start: got %0d starts expected 0", start_q.size()); end
    checks++; if (lp_blank !== 1'b1) begin errors++;
      $display("FAIL idle_blank: got %b expected 1", lp_blank); end
    c = cyc;
    enable = 1'b1;
    repeat (4) @(negedge clock);
    #1;
    checks++; if (start_q.size() < 1) begin errors++;
      $display("FAIL first_start_seen: got %0d starts expected 1", start_q.size());
    end else begin
      checks++; if (start_cyc_q[0] != c + 1) begin errors++;
        $display("FAIL first_start_cycle: got %0d expected %0d", start_cyc_q[0], c + 1); end
      checks++; if (start_q[0] != 0) begin errors++;
        $display("FAIL first_start_pos: got %0d expected 0", start_q[0]); end
    end
  endtask

  task automatic test_scan();
    bit ok;
    do_reset();
    rand_delay = 1;
    enable = 1'b1;
    wait_latches(34, 6000, ok);
    checks++; if (!ok) begin errors++;
      $display("FAIL scan_timeout: got %0d latches expected 34", lat_addr_q.size()); return; end
    for (int n = 0; n <= 32; n++) begin
      checks++; if (start_q[n] != exp_pos(n)) begin errors++;
        $display("FAIL scan_start[%0d]: got %0d expected %0d", n, start_q[n], exp_pos(n)); end
      checks++; if (lat_addr_q[n] != exp_row(n)) begin errors++;
        $display("FAIL scan_addr[%0d]: got %0d expected %0d", n, lat_addr_q[n], exp_row(n)); end
      checks++; if (low_q[n] != on_time(exp_plane(n))) begin errors++;
        $display("FAIL scan_lit[%0d]: got %0d expected %0d", n, low_q[n], on_time(exp_plane(n))); end
    end
    for (int n = 1; n <= 32; n++) begin
      checks++; if (win_len_q[n] != 2 || win_at_q[n] != 2) begin errors++;
        $display("FAIL scan_window[%0d]: got len %0d latch_at %0d expected 2 2", n, win_len_q[n], win_at_q[n]); end
    end
    checks++; if (win_at_q[0] != win_len_q[0]) begin errors++;
      $display("FAIL first_latch_last: got %0d expected %0d", win_at_q[0], win_len_q[0]); end
    checks++; if (tick_cyc_q.size() != 1) begin errors++;
      $display("FAIL tick_count: got %0d expected 1", tick_cyc_q.size());
    end else begin
      checks++; if (tick_cyc_q[0] != lat_cyc_q[31] + 2) begin errors++;
        $display("FAIL tick_cycle: got %0d expected %0d", tick_cyc_q[0], lat_cyc_q[31] + 2); end
      checks++; if (tick_cyc_q[0] != start_cyc_q[32]) begin errors++;
        $display("FAIL tick_vs_start: got %0d expected %0d", tick_cyc_q[0], start_cyc_q[32]); end
      checks++; if (tick_ack_q[0] != 0 || ack_cnt != 0) begin errors++;
        $display("FAIL no_swap_ack: got %0d expected 0", ack_cnt); end
    end
    checks++; if (latch_while_lit != 0) begin errors++;
      $display("FAIL latch_while_lit: got %0d expected 0", latch_while_lit); end
  endtask

  task automatic test_swap();
    bit ok;
    int exp_buf;
    int tgt;
    do_reset();
    rand_delay = 1;
    enable = 1'b1;
    exp_buf = 0;
    tgt = int'($urandom_range(3, 28));
    wait_latches(tgt, 4000, ok);
    @(posedge clock); #1 swap_req = 1'b1;
    for (int t = 1; t <= 3; t++) begin
      wait_ticks(t, 6000, ok);
      checks++; if (!ok) begin errors++;
        $display("FAIL swap_tick_timeout[%0d]: got %0d ticks expected %0d", t, tick_cyc_q.size(), t); return; end
      if (t < 3) exp_buf = 1 - exp_buf;
      checks++; if (tick_ack_q[t-1] != ((t < 3) ? 1 : 0)) begin errors++;
        $display("FAIL swap_ack[%0d]: got %0d expected %0d", t, tick_ack_q[t-1], (t < 3) ? 1 : 0); end
      checks++; if (tick_buf_q[t-1] != exp_buf) begin errors++;
        $display("FAIL buffer_sel[%0d]: got %0d expected %0d", t, tick_buf_q[t-1], exp_buf); end
      checks++; if (ack_cnt != ((t < 3) ? t : 2)) begin errors++;
        $display("FAIL ack_count[%0d]: got %0d expected %0d", t, ack_cnt, (t < 3) ? t : 2); end
      if (t == 2) begin
        wait_latches(lat_addr_q.size() + 2, 1000, ok);
        @(posedge clock); #1 swap_req = 1'b0;
      end
    end
  endtask

  task automatic test_slow_shift();
    bit ok;
    do_reset();
    rand_delay = 0;
    slow_idx = 1;
    slow_delay = 500;
    enable = 1'b1;
    wait_latches(3, 1500, ok);
    checks++; if (!ok) begin errors++;
      $display("FAIL slow_timeout: got %0d latches expected 3", lat_addr_q.size()); return; end
    checks++; if (start_q[1] != exp_pos(1)) begin errors++;
      $display("FAIL slow_start_pos: got %0d expected %0d", start_q[1], exp_pos(1)); end
    checks++; if (low_q[0] < 500) begin errors++;
      $display("FAIL slow_lit_len: got %0d expected >= 500", low_q[0]); end
    checks++; if (rise_cyc_q[0] != slow_done_cyc + 2) begin errors++;
      $display("FAIL slow_blank_rise: got %0d expected %0d", rise_cyc_q[0], slow_done_cyc + 2); end
    checks++; if (lat_cyc_q[1] != slow_done_cyc + 3) begin errors++;
      $display("FAIL slow_latch_cycle: got %0d expected %0d", lat_cyc_q[1], slow_done_cyc + 3); end
    checks++; if (low_q[1] != on_time(1)) begin errors++;
      $display("FAIL slow_next_lit: got %0d expected %0d", low_q[1], on_time(1)); end
  endtask

  task automatic test_enable_drain();
    bit ok;
    int k;
    int s0;
    int l0;
    int c;
    do_reset();
    rand_delay = 1;
    enable = 1'b1;
    k = 12 + int'($urandom_range(0, 3));
    wait_latches(k + 1, 3000, ok);
    @(posedge clock); #1 enable = 1'b0;
    repeat (600) @(posedge clock);
    #1;
    checks++; if (start_q.size() != k + 1) begin errors++;
      $display("FAIL drain_starts: got %0d expected %0d", start_q.size(), k + 1); end
    checks++; if (lat_addr_q.size() != k + 1) begin errors++;
      $display("FAIL drain_latches: got %0d expected %0d", lat_addr_q.size(), k + 1); end
    checks++; if (low_q.size() != k + 1) begin errors++;
      $display("FAIL drain_runs: got %0d expected %0d", low_q.size(), k + 1);
    end else begin
      checks++; if (low_q[k] != on_time(exp_plane(k))) begin errors++;
        $display("FAIL drain_lit: got %0d expected %0d", low_q[k], on_time(exp_plane(k))); end
    end
    checks++; if (lp_blank !== 1'b1 || lp_latch !== 1'b0) begin errors++;
      $display("FAIL drain_blank: got %b%b expected 10", lp_blank, lp_latch); end
    s0 = start_q.size();
    l0 = lat_addr_q.size();
    c = cyc;
    enable = 1'b1;
    wait_latches(l0 + 3, 1000, ok);
    checks++; if (!ok || start_q.size() <= s0 || low_q.size() < l0 + 2) begin errors++;
      $display("FAIL restart_timeout: got %0d latches expected %0d", lat_addr_q.size(), l0 + 3); return; end
    checks++; if (start_q[s0] != 0 || start_cyc_q[s0] != c + 1) begin errors++;
      $display("FAIL restart_start: got pos %0d cyc %0d expected 0 %0d", start_q[s0], start_cyc_q[s0], c + 1); end
    checks++; if (lat_addr_q[l0] != 0 || lat_addr_q[l0 + 2] != 0) begin errors++;
      $display("FAIL restart_addr: got %0d %0d expected 0 0", lat_addr_q[l0], lat_addr_q[l0 + 2]); end
    checks++; if (low_q[l0] != on_time(0) || low_q[l0 + 1] != on_time(1)) begin errors++;
      $display("FAIL restart_lit: got %0d %0d expected %0d %0d", low_q[l0], low_q[l0 + 1], on_time(0), on_time(1)); end
  endtask

  task automatic test_reset_mid_latch();
    bit ok;
    bit found;
    do_reset();
    rand_delay = 1;
    enable = 1'b1;
    swap_req = 1'b1;
    wait_ticks(1, 6000, ok);
    checks++; if (!ok || tick_buf_q[0] != 1) begin errors++;
      $display("FAIL pre_reset_swap: got %b expected 1", buffer_sel); end
    found = 1'b0;
    for (int i = 0; i < 700; i++) begin
      @(negedge clock);
      if (lp_latch) begin found = 1'b1; break; end
    end
    checks++; if (!found) begin errors++;
      $display("FAIL latch_wait_timeout: got 0 latches expected 1"); end
    #2 reset_n = 1'b0;
    #1;
    checks++; if (lp_latch !== 1'b0 || lp_blank !== 1'b1) begin errors++;
      $display("FAIL reset_mid_latch: got latch %b blank %b expected 0 1", lp_latch, lp_blank); end
    checks++; if (buffer_sel !== 1'b0 || lp_address !== 3'd0) begin errors++;
      $display("FAIL reset_mid_buf: got buf %b addr %0d expected 0 0", buffer_sel, lp_address); end
    checks++; if ({shift_start, swap_ack, frame_tick, shift_row, shift_plane} !== 8'd0) begin errors++;
      $display("FAIL reset_mid_misc: got %b expected 0", {shift_start, swap_ack, frame_tick, shift_row, shift_plane}); end
    do_reset();
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_scan();
    test_swap();
    test_slow_shift();
    test_enable_drain();
    test_reset_mid_latch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/panel_scan_scheduler.md
PANEL_SCAN_SCHEDULER -- requirements
Module: panel_scan_scheduler

Interface
REQ-001 The block SHALL have parameter ROW_BITS, default 3, giving the row-pair address width (8 row pairs for a 16x32 panel).
REQ-002 The block SHALL have parameter PLANE_BITS, default 2, giving the bitplane index width (4 planes).
REQ-003 The block SHALL have parameter BASE_ON, default 32, giving the on-time in clock cycles of plane 0.
REQ-004 The block SHALL have parameter TIMER_BITS, default 16, giving the on-timer width; BASE_ON<<(2**PLANE_BITS-1) SHALL be less than 2**TIMER_BITS.
REQ-005 The block SHALL have one clock and an asynchronous active-low reset: CLOCK in 1, system clock; RESET_N in 1, asynchronous active-low reset.
REQ-006 ENABLE in 1: scanning permitted.
REQ-007 SHIFT_START out 1: one-cycle pulse requesting the row shifter to load SHIFT_ROW/SHIFT_PLANE.
REQ-008 SHIFT_ROW out ROW_BITS and SHIFT_PLANE out PLANE_BITS: position being shifted; stable from SHIFT_START until SHIFT_DONE.
REQ-009 SHIFT_DONE in 1: one-cycle pulse from the shifter when all columns are shifted.
REQ-010 LP_BLANK out 1, LP_LATCH out 1, LP_ADDRESS out ROW_BITS: panel control.
REQ-011 SWAP_REQ in 1 (level), SWAP_ACK out 1 (pulse), BUFFER_SEL out 1: double-buffer select for the frame reader.
REQ-012 FRAME_TICK out 1: one-cycle pulse at each frame boundary.

Function
REQ-013 Scan order SHALL be plane-inner, row-outer: (r,p) advances p first; after (2**ROW_BITS-1, 2**PLANE_BITS-1) it wraps to (0,0).
REQ-014 States SHALL be IDLE, SHIFT, WAIT_ON, BLANK, LATCH, UNBLANK, DRAIN.
REQ-015 IDLE: LP_BLANK=1. When ENABLE=1, it SHALL pulse SHIFT_START for (0,0) and go to SHIFT.
REQ-016 SHIFT: it SHALL wait for SHIFT_DONE, then go to WAIT_ON. SHIFT_DONE in any other state SHALL be ignored.
REQ-017 The on-timer SHALL decrement every cycle while nonzero, in every state.
REQ-018 WAIT_ON: when the timer is 0, it SHALL go to BLANK and drive LP_BLANK=1.
REQ-019 BLANK -> LATCH: the block SHALL drive LP_LATCH=1 and set LP_ADDRESS=SHIFT_ROW.
REQ-020 LATCH -> UNBLANK: the block SHALL drive LP_LATCH=0 and LP_BLANK=0, and load the timer with BASE_ON<<p of the position just latched.
REQ-021 Each latch SHALL show as LP_BLANK high for exactly 2 cycles, with LP_LATCH high for exactly the second.
REQ-022 UNBLANK with ENABLE=1: the block SHALL advance the position, pulse SHIFT_START for it and go to SHIFT, so shifting overlaps display.
REQ-023 UNBLANK with ENABLE=0: the block SHALL go to DRAIN with no SHIFT_START.
REQ-024 DRAIN: when the timer is 0, the block SHALL drive LP_BLANK=1, reset the position to (0,0) and go to IDLE.
REQ-025 If the shifter is faster than the on-time, LP_BLANK low SHALL last exactly BASE_ON<<p cycles. If it is slower, LP_BLANK SHALL stay low until SHIFT_DONE, with latching 1 cycle later.
REQ-026 Frame boundary is the UNBLANK cycle that wraps the position to (0,0). There the block SHALL pulse FRAME_TICK.
REQ-027 If SWAP_REQ=1 at the frame boundary, the block SHALL toggle BUFFER_SEL and pulse SWAP_ACK in the same cycle, so the (0,0) SHIFT_START uses the new buffer.
REQ-028 SWAP_REQ SHALL otherwise be ignored. A held SWAP_REQ SHALL produce one ACK per frame boundary.
REQ-029 If ENABLE=0 at the frame boundary, FRAME_TICK SHALL still pulse and the swap SHALL still be honoured.

Reset
REQ-030 RESET_N=0 SHALL immediately force state IDLE, timer 0, position (0,0), LP_BLANK=1, LP_LATCH=0, LP_ADDRESS=0, SHIFT_START=0, SHIFT_ROW=0, SHIFT_PLANE=0, BUFFER_SEL=0, SWAP_ACK=0 and FRAME_TICK=0, including mid-latch or mid-shift.
REQ-031 After RESET_N rises, the first SHIFT_START SHALL occur 1 cycle after ENABLE is sampled high.

Verification (ROW_BITS=3, PLANE_BITS=2, BASE_ON=32)
REQ-032 Reset, ENABLE=1, SHIFT_DONE 5 cycles after each start -> SHIFT_START (0,0), then (0,1). Latches SHALL occur with LP_ADDRESS=0 and LP_BLANK low runs of 32, 64, 128, 256 cycles, then LP_ADDRESS=1.
REQ-033 Full frame -> 32 latches, then position (7,3) -> (0,0) with a single FRAME_TICK pulse.
REQ-034 SWAP_REQ=1 mid-frame -> SWAP_ACK single pulse coincident with FRAME_TICK, BUFFER_SEL 0->1; held through the next boundary -> 1->0.
REQ-035 SHIFT_DONE delayed 500 cycles on plane 0 -> LP_BLANK held low 500+ cycles; LP_LATCH pulse 2 cycles after SHIFT_DONE.
REQ-036 ENABLE=0 at row 3 -> current on-time completes, then LP_BLANK=1 and no further SHIFT_START. ENABLE=1 -> restart at (0,0).
REQ-037 RESET_N=0 while LP_LATCH=1 -> same-cycle LP_LATCH=0, LP_BLANK=1, BUFFER_SEL=0.
